// File: rtl/sdram_device_model.sv
// rtl/sdram_device_model.sv - behavioural SDRAM device: per-bank timing, CAS-latency reads, first-error capture
module sdram_device_model #(
    parameter int BA_BITS     = 2,
    parameter int ROW_BITS    = 4,
    parameter int COL_BITS    = 4,
    parameter int CAS_LATENCY = 2,
    parameter int TRCD        = 2,
    parameter int TRP         = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         sdram_cmd,
    input  logic [BA_BITS-1:0] sdram_ba,
    input  logic [12:0]        sdram_a,
    input  logic [1:0]         sdram_dqm,
    input  logic [15:0]        sdram_data_in,
    input  logic               sdram_data_in_en,
    output logic [15:0]        sdram_data_out,
    output logic               sdram_data_out_en,
    output logic               err,
    output logic [2:0]         err_code
);
    localparam int NBANK = 1 << BA_BITS;
    localparam int DEPTH = 1 << (BA_BITS + ROW_BITS + COL_BITS);
    localparam int CMAX  = (TRCD > TRP) ? TRCD : TRP;
    localparam int CW    = $clog2(CMAX + 1);

    localparam logic [CW-1:0] CNT_MAX = CW'(CMAX);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] TRCD_C  = CW'(TRCD);
    localparam logic [CW-1:0] TRP_C   = CW'(TRP);

    localparam logic [2:0] CMD_REFRESH   = 3'b001;
    localparam logic [2:0] CMD_PRECHARGE = 3'b010;
    localparam logic [2:0] CMD_ACTIVATE  = 3'b011;
    localparam logic [2:0] CMD_WRITE     = 3'b100;
    localparam logic [2:0] CMD_READ      = 3'b101;

    logic [15:0]         mem [DEPTH];
    logic [NBANK-1:0]    bank_active;
    logic [ROW_BITS-1:0] open_row [NBANK];
    logic [CW-1:0]       act_cnt  [NBANK];
    logic [CW-1:0]       pre_cnt  [NBANK];

    logic [CAS_LATENCY-1:0] pipe_vld;
    logic [15:0]            pipe_data [CAS_LATENCY];

    logic is_act, is_rd, is_wr, is_pre, is_ref;
    logic act_ok, rw_ok, rd_fire;
    logic [2:0] viol;
    logic [BA_BITS+ROW_BITS+COL_BITS-1:0] addr;
    logic [15:0] rd_word;
    logic unused_a;

    assign unused_a = ^sdram_a;

    assign is_act = (sdram_cmd == CMD_ACTIVATE);
    assign is_rd  = (sdram_cmd == CMD_READ);
    assign is_wr  = (sdram_cmd == CMD_WRITE);
    assign is_pre = (sdram_cmd == CMD_PRECHARGE);
    assign is_ref = (sdram_cmd == CMD_REFRESH);

    assign act_ok  = is_act && !bank_active[sdram_ba] && (pre_cnt[sdram_ba] >= TRP_C);
    assign rw_ok   = (is_rd || is_wr) && bank_active[sdram_ba] && (act_cnt[sdram_ba] >= TRCD_C);
    assign rd_fire = rw_ok && is_rd;
    assign addr    = {sdram_ba, open_row[sdram_ba], sdram_a[COL_BITS-1:0]};

    // Only one command per cycle, so the chain order is the lowest-code-wins priority.
    always_comb begin
        viol = 3'd0;
        if (is_act && bank_active[sdram_ba])
            viol = 3'd1;
        else if ((is_rd || is_wr) && !bank_active[sdram_ba])
            viol = 3'd2;
        else if ((is_rd || is_wr) && (act_cnt[sdram_ba] < TRCD_C))
            viol = 3'd3;
        else if (is_act && (pre_cnt[sdram_ba] < TRP_C))
            viol = 3'd4;
        else if (is_ref && (|bank_active))
            viol = 3'd5;
        else if (sdram_data_in_en && sdram_data_out_en)
            viol = 3'd6;
    end

    always_comb begin
        rd_word = mem[addr];
        if (sdram_dqm[0]) rd_word[7:0]  = 8'h00;
        if (sdram_dqm[1]) rd_word[15:8] = 8'h00;
    end

    // Counters hold "cycles since event", starting at 1 in the cycle after the event.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_active <= '0;
            for (int b = 0; b < NBANK; b++) begin
                open_row[b] <= '0;
                act_cnt[b]  <= CNT_MAX;
                pre_cnt[b]  <= CNT_MAX;
            end
        end else begin
            for (int b = 0; b < NBANK; b++) begin
                if (act_cnt[b] != CNT_MAX) act_cnt[b] <= act_cnt[b] + CNT_ONE;
                if (pre_cnt[b] != CNT_MAX) pre_cnt[b] <= pre_cnt[b] + CNT_ONE;
                if (bank_active[b] &&
                    ((is_pre && (sdram_a[10] || (BA_BITS'(b) == sdram_ba))) ||
                     (rw_ok && sdram_a[10] && (BA_BITS'(b) == sdram_ba)))) begin
                    bank_active[b] <= 1'b0;
                    pre_cnt[b]     <= CNT_ONE;
                end
            end
            if (act_ok) begin
                bank_active[sdram_ba] <= 1'b1;
                open_row[sdram_ba]    <= sdram_a[ROW_BITS-1:0];
                act_cnt[sdram_ba]     <= CNT_ONE;
            end
        end
    end

    // Storage has no reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (rw_ok && is_wr) begin
            if (!sdram_dqm[0]) mem[addr][7:0]  <= sdram_data_in[7:0];
            if (!sdram_dqm[1]) mem[addr][15:8] <= sdram_data_in[15:8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld <= '0;
            for (int i = 0; i < CAS_LATENCY; i++) pipe_data[i] <= '0;
        end else begin
            pipe_vld[0]  <= rd_fire;
            pipe_data[0] <= rd_fire ? rd_word : 16'h0000;
            for (int i = 1; i < CAS_LATENCY; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_data[i] <= pipe_data[i-1];
            end
        end
    end

    assign sdram_data_out_en = pipe_vld[CAS_LATENCY-1];
    assign sdram_data_out    = pipe_data[CAS_LATENCY-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            err      <= 1'b0;
            err_code <= 3'd0;
        end else if (!err && (viol != 3'd0)) begin
            err      <= 1'b1;
            err_code <= viol;
        end
    end
endmodule

// File: doc/sdram_device_model.md
SDRAM_DEVICE_MODEL -- requirements
Module: sdram_device_model

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- BA_BITS, 2, bank address width
- ROW_BITS, 4, row address bits used (upper A bits ignored)
- COL_BITS, 4, column address bits used
- CAS_LATENCY, 2, read command to data valid cycles
- TRCD, 2, minimum cycles from ACTIVATE to READ/WRITE, same bank
- TRP, 2, minimum cycles from precharge to ACTIVATE, same bank
REQ-002 Ports SHALL be (name direction width meaning):
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- sdram_cmd  in  3  {RAS_n,CAS_n,WE_n}: 000 LOADMODE, 001 REFRESH, 010 PRECHARGE, 011 ACTIVATE, 100 WRITE, 101 READ, 110 BURST_TERM, 111 NOP
- sdram_ba  in  BA_BITS  bank select
- sdram_a  in  13  row on ACTIVATE; column plus A10 auto-precharge on READ/WRITE; A10 all-banks on PRECHARGE
- sdram_dqm  in  2  byte mask, bit1 upper, bit0 lower, 1 = masked
- sdram_data_in  in  16  write data from controller
- sdram_data_in_en  in  1  controller is driving the data bus
- sdram_data_out  out  16  read data to controller
- sdram_data_out_en  out  1  model is driving read data
- err  out  1  sticky protocol-violation flag
- err_code  out  3  code of first violation

Function
REQ-003 Storage SHALL be 2^(BA_BITS+ROW_BITS+COL_BITS) x 16-bit words, indexed {bank, open row, column}; initial contents 16'h0000.
REQ-004 Each bank SHALL hold state IDLE or ACTIVE, an open-row register, and saturating counters: cycles since ACTIVATE, cycles since precharge.
REQ-005 ACTIVATE to IDLE bank with TRP satisfied SHALL -> ACTIVE, latch sdram_a[ROW_BITS-1:0], reset its ACT counter.
REQ-006 WRITE to ACTIVE bank SHALL write in the command cycle: lane i stored from sdram_data_in only if sdram_dqm[i]=0 (write DQM latency 0).
REQ-007 READ to ACTIVE bank SHALL, exactly CAS_LATENCY cycles later, assert sdram_data_out_en=1 for one cycle with the addressed word; lane i forced to 8'h00 if sdram_dqm[i]=1 in the READ command cycle.
REQ-008 Read pipeline SHALL accept a READ every cycle; pending reads deliver independently in order.
REQ-009 READ/WRITE with A10=1 SHALL return the bank to IDLE next cycle and reset its precharge counter (burst length 1).
REQ-010 PRECHARGE SHALL idle bank sdram_ba (A10=0) or all banks (A10=1) next cycle; precharging an IDLE bank is legal, no effect.
REQ-011 LOADMODE, BURST_TERM, NOP SHALL have no effect; REFRESH SHALL have no data effect.
REQ-012 Violations SHALL set err with err_code: 1 ACTIVATE to ACTIVE bank; 2 READ/WRITE to IDLE bank; 3 READ/WRITE before TRCD; 4 ACTIVATE before TRP; 5 REFRESH with any bank ACTIVE; 6 sdram_data_in_en and sdram_data_out_en both 1.
REQ-013 err and err_code SHALL register one cycle after the violation; only the first violation is recorded; later ones ignored until reset.
REQ-014 Lowest code SHALL win for simultaneous violations.
REQ-015 Violating commands SHALL not alter bank state or memory (ACTIVATE, WRITE, READ ignored); contention does not cancel read data.
REQ-016 Counters SHALL saturate at max(TRCD,TRP); counters initialise saturated.

Reset
REQ-017 rst SHALL set all banks IDLE, counters saturated, read pipeline cleared, sdram_data_out=0, sdram_data_out_en=0, err=0, err_code=0.
REQ-018 rst mid-read SHALL cancel pending read data; memory contents SHALL be retained through reset.

Verification
REQ-019 ACT b0 row 3 @t0, WRITE b0 col 5 A10=1 data 16'hA55A dqm 00 @t2, ACT @t8, READ @t10 dqm 00 -> out_en=1, data 16'hA55A @t12, err=0.
REQ-020 Write 16'h1234 then WRITE 16'hFFFF dqm 10, read back -> 16'h12FF; read with dqm 01 -> 16'h1200.
REQ-021 Interleaved: ACT b0 @0, ACT b1 @1, READ b0 @2, READ b1 @3 -> data b0 @4, b1 @5, no err.
REQ-022 ACT b0 @0, READ b0 @1 -> err=1, err_code=3 @2, no read data; subsequent ACT to ACTIVE b0 leaves err_code=3.
REQ-023 READ with A10=1 @t, ACT same bank @t+2 (TRP=2 met) -> no err; @t+1 instead -> err_code=4.
REQ-024 READ @t, rst @t+1 -> out_en stays 0 at t+2; err cleared; prior written data still readable.
